// File: rtl/ifetch_seq.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_seq
// Brief    : Sequential instruction fetch with a ready handshake and next-PC
//            selection. Define IFETCH_ALIGN_TRAP_EN to trap misaligned targets.
// Revision : 1.0 - initial release
// ============================================================================
module ifetch_seq #(
  parameter int          ADDR_W   = 14,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clock,
  input  logic              reset_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instruction,
  output logic [31:0]       pc,
  output logic [31:0]       link_addr,
  output logic              instr_valid,
  input  logic              instr_ack,
  input  logic              branch,
  input  logic              nbranch,
  input  logic              jmp,
  input  logic              jal,
  input  logic              jr,
  input  logic              zero,
  input  logic [31:0]       branch_addr,
  input  logic [31:0]       read_data_1
`ifdef IFETCH_ALIGN_TRAP_EN
  ,
  output logic              fault
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_VALID = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t            state_q;
  logic [31:0]       pc_q;
  logic [31:0]       instr_q;
  logic              valid_q;
  logic              req_q;
  logic [ADDR_W-1:0] addr_q;

  logic [31:0]       pc_plus4;
  logic              taken;
  logic [31:0]       pc_sel;
  logic [31:0]       pc_d;
  logic              unused_bits;

  assign unused_bits = ^branch_addr[31:30];

  always_comb begin
    pc_plus4 = pc_q + 32'd4;
    taken    = (branch & zero) | (nbranch & ~zero);
    pc_sel   = pc_plus4;
    if (jr) begin
      pc_sel = read_data_1;
    end else if (jmp | jal) begin
      pc_sel = {pc_plus4[31:28], instr_q[25:0], 2'b00};
    end else if (taken) begin
      pc_sel = {branch_addr[29:0], 2'b00};
    end
    // Only jr can produce a misaligned target; the low bits are dropped here.
    pc_d = {pc_sel[31:2], 2'b00};
  end

`ifdef IFETCH_ALIGN_TRAP_EN
  logic fault_q;
  logic misaligned;
  assign misaligned = |pc_sel[1:0];
  assign fault      = fault_q;
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
      valid_q <= 1'b0;
      req_q   <= 1'b0;
      addr_q  <= '0;
`ifdef IFETCH_ALIGN_TRAP_EN
      fault_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q <= S_FETCH;
          req_q   <= 1'b1;
          addr_q  <= pc_q[ADDR_W+1:2];
        end
        S_FETCH: begin
          if (imem_ready) begin
            instr_q <= imem_rdata;
            valid_q <= 1'b1;
            req_q   <= 1'b0;
            state_q <= S_VALID;
          end
        end
        S_VALID: begin
          if (instr_ack) begin
            valid_q <= 1'b0;
`ifdef IFETCH_ALIGN_TRAP_EN
            if (misaligned) begin
              state_q <= S_FAULT;
              fault_q <= 1'b1;
            end else begin
              pc_q    <= pc_d;
              state_q <= S_FETCH;
              req_q   <= 1'b1;
              addr_q  <= pc_d[ADDR_W+1:2];
            end
`else
            pc_q    <= pc_d;
            state_q <= S_FETCH;
            req_q   <= 1'b1;
            addr_q  <= pc_d[ADDR_W+1:2];
`endif
          end
        end
        S_FAULT: begin
          state_q <= S_FAULT;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign instruction = instr_q;
  assign pc          = pc_q;
  assign link_addr   = pc_q + 32'd4;
  assign instr_valid = valid_q;

endmodule
`default_nettype wire

// File: doc/ifetch_seq.md
# ifetch_seq

Sequential instruction-fetch and PC-update unit for the single-issue MIPS-subset core. It is the consumer of the execute stage's branch-resolution outputs: the zero flag, the word-granular branch target, and the jr register operand. It fetches each instruction from the instruction ROM over a ready handshake, holds it for the decode/execute stages until acknowledged, and then selects the next PC.

## Interface
Parameters:
- ADDR_W, 14, instruction-memory word-address width; `imem_addr = pc[ADDR_W+1:2]`
- RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
- clock  in  1  single clock; all state updates on the rising edge
- reset_n  in  1  reset, synchronous and active-low
- imem_req  out  1  fetch request to the instruction ROM
- imem_addr  out  ADDR_W  word address of the fetch
- imem_ready  in  1  ROM data valid this cycle; ignored unless imem_req=1
- imem_rdata  in  32  instruction word from the ROM
- instruction  out  32  captured instruction, stable while instr_valid=1
- pc  out  32  address of the held instruction
- link_addr  out  32  pc+4, the jal return value
- instr_valid  out  1  instruction and pc are valid
- instr_ack  in  1  downstream has consumed the instruction; the resolution inputs are sampled in the same cycle
- branch, nbranch, jmp, jal, jr  in  1 each  control decode of the held instruction
- zero  in  1  ALU zero flag from execute
- branch_addr  in  32  execute branch target in word units, i.e. (pc+4)>>2 + sign-extended immediate
- read_data_1  in  32  rs value, used as the jr target
- fault  out  1  sticky misaligned-target flag; present only when the configuration macro is defined

## Operation
- States:
  - IDLE: one cycle after reset
  - FETCH: imem_req=1; on imem_ready, capture imem_rdata into instruction and go to VALID; otherwise stay in FETCH
  - VALID: instr_valid=1; on instr_ack, load next_pc into pc and go to FETCH
  - FAULT: terminal state; exited only by reset
- Transitions: IDLE→FETCH unconditionally.
- Next-PC priority, highest first:
  - jr: read_data_1
  - jmp or jal: {pc_plus4[31:28], instruction[25:0], 2'b00}
  - taken branch, defined as (branch & zero) | (nbranch & ~zero): {branch_addr[29:0], 2'b00}
  - otherwise: pc_plus4
- pc_plus4 = pc + 32'd4, computed modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- If several control inputs are asserted together, the priority above decides; no error is raised.
- link_addr is combinational from the pc register.
- Bits of pc above ADDR_W+1 do not reach imem_addr.
- Control inputs are ignored in every state except VALID with instr_ack=1.

## Timing
- Reset values: pc=RESET_PC, instruction=0, instr_valid=0, imem_req=0, imem_addr=0, fault=0, state=IDLE. link_addr=RESET_PC+4.
- Cycle after reset release: IDLE. Following cycle: FETCH, with imem_addr=RESET_PC[ADDR_W+1:2].
- Minimum throughput: one instruction per 2 cycles (FETCH with ready=1, then VALID with ack=1). Each cycle of ROM wait or withheld ack adds one cycle.
- imem_addr and imem_req are registered; both are stable for the whole FETCH stay.
- instruction, pc and instr_valid do not change while in VALID without ack.
- Reset asserted mid-fetch: the next edge returns to the reset values. An imem_ready arriving afterwards is ignored.

## Configuration
- IFETCH_ALIGN_TRAP_EN defined:
  - A selected next_pc with bits [1:0] ≠ 0 (jr only) moves the FSM from VALID to FAULT instead of FETCH.
  - In FAULT: fault=1, imem_req=0, instr_valid=0, pc unchanged.
- Undefined:
  - next_pc[1:0] is forced to 2'b00 and fetch continues.
  - The fault port does not exist.

## Test plan
- Reset then free-run, ROM ready=1, ack=1, no control → imem_addr sequence 0,1,2,3 on every second cycle; pc=0,4,8,C; link_addr=pc+4.
- pc=0x40, branch=1, zero=1, branch_addr=0x00000015 → next pc=0x54. Same with zero=0 → pc=0x44. nbranch=1, zero=0 → pc=0x54.
- pc=0x0000_1000, instruction=0x0C000100 with jal=1 → pc=0x400, and link_addr=0x1004 visible with the jal instruction.
- jr=1 and branch=1, zero=1 together, read_data_1=0x200 → pc=0x200 (jr priority). With read_data_1=0x202: trap build enters FAULT with fault=1 and no further imem_req; non-trap build goes to pc=0x200.
- ROM withholds ready for 3 cycles, then ack withheld for 2 cycles → imem_req/imem_addr held 4 cycles, instruction held 3 cycles, exactly one pc advance.
- Pull reset_n low while in FETCH at pc=0x80 → next cycle pc=0, imem_req=0, instr_valid=0; a ready pulse during reset causes no capture.
